pipe_stage_reg: RTL and testbench

//  Parametrised, handshaked pipeline stage register; successor to the fixed per-stage latches.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 59 +++++
 rtl/pipe_stage_reg.sv | 71 +++++++
 tb/tb_pipe_stage_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: the write-back payload layout and the invalid/reset
// constants the core stages use when a slot holds no instruction.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rw_data;
    logic [4:0]  rw_addr;
    logic        rw_en;
  } wb_payload_t;

  localparam int PIPE_PAYLOAD_W = $bits(wb_payload_t);

  localparam logic [31:0] ADDR_INVALID = 32'hFFFF_FFFF;
  localparam logic [31:0] DATA_INVALID = 32'h0000_0000;
  localparam logic [4:0]  REG_INVALID  = 5'd0;
  localparam logic        RST_VALID    = 1'b0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) stage storage with a registered in_ready.
// Only compiled when PIPE_STAGE_SKID_EN is defined.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int             W       = PIPE_PAYLOAD_W,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;
  logic         in_fire, out_fire;

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      main_valid <= RST_VALID;
      skid_valid <= RST_VALID;
      main_data  <= RST_VAL;
      skid_data  <= RST_VAL;
    end else if (out_fire || !main_valid) begin
      // Main slot frees up: the older skid entry has priority over new input.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= RST_VAL;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= RST_VAL;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W   = PIPE_PAYLOAD_W,
  parameter logic [PAYLOAD_W-1:0] RST_PAYLOAD = '0,
  parameter int                   CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_buf #(
    .W       (PAYLOAD_W),
    .RST_VAL (RST_PAYLOAD)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );
`else
  logic in_fire, out_fire;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  // NOTE: the payload register is reset as well, because out_data must read
  // RST_PAYLOAD (not stale data) whenever the stage is empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= RST_VALID;
      out_data  <= RST_PAYLOAD;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_data  <= RST_PAYLOAD;
    end
  end
`endif

  // Counts stalled cycles even during a flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + scoreboard bench for pipe_stage_reg; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = PIPE_PAYLOAD_W;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [15:0]   stall_cnt;
  logic          in_ready4, out_valid4;
  logic [W-1:0]  out_data4;
  logic [3:0]    stall_cnt4;

  int checks   = 0;
  int failures = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic [W-1:0] exp_od;
  } vec_t;

  vec_t vecs[9];
  logic [W-1:0] q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic [W-1:0] d, input logic ordy);
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int xfers;
    logic [127:0] r;
    logic fl, iv, ordy;

    // 1: reset while offering data
    rst = 1'b1;
    drive(1'b0, 1'b1, W'('hA5), 1'b1);
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    check("rst_in_ready", in_ready, 1);

    // 2: streaming 1..8, table driven
    for (int k = 0; k < 8; k++) begin
      vecs[k].iv = 1'b1;   vecs[k].d = W'(k + 1);  vecs[k].ordy = 1'b1;
      vecs[k].exp_ir = 1'b1; vecs[k].exp_ov = 1'b1; vecs[k].exp_od = W'(k + 1);
    end
    vecs[8].iv = 1'b0;   vecs[8].d = '0;  vecs[8].ordy = 1'b1;
    vecs[8].exp_ir = 1'b1; vecs[8].exp_ov = 1'b0; vecs[8].exp_od = '0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
    end

    // 3: stall with a second payload offered
    drive(1'b0, 1'b1, W'('h11), 1'b0);
    tick();
    check("stall_load", out_data, 'h11);
    drive(1'b0, 1'b1, W'('h22), 1'b0);
    #1;
    check("stall_first_in_ready", in_ready, SKID ? 1 : 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_data", i), out_data, 'h11);
      check($sformatf("stall%0d_valid", i), out_valid, 1);
    end
    check("stall_cnt5", stall_cnt, 5);
    check("stall_cnt5_w4", stall_cnt4, 5);
    check("stall_in_ready", in_ready, 0);
    drive(1'b0, 1'b1, W'('h22), 1'b1);
    #1;
    check("release_in_ready", in_ready, SKID ? 0 : 1);
    tick();
    check("release_data", out_data, 'h22);
    check("release_valid", out_valid, 1);
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    check("release_drain_valid", out_valid, 0);
    check("release_drain_data", out_data, 0);

    // 4: flush while stalled (skid build also holds 0x55 in the skid entry)
    drive(1'b0, 1'b1, W'('h33), 1'b0);
    tick();
    check("flush_load", out_data, 'h33);
    drive(1'b0, 1'b1, W'('h55), 1'b0);
    tick();
    check("flush_hold", out_data, 'h33);
    drive(1'b1, 1'b1, W'('h44), 1'b0);
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, 0);
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_flush%0d_valid", i), out_valid, 0);
    end
    drive(1'b1, 1'b1, W'('h66), 1'b1);
    #1;
    check("flush_empty_in_ready", in_ready, 1);
    tick();
    check("flush_drop_valid", out_valid, 0);
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    check("flush_drop_valid2", out_valid, 0);

    // 5: saturation of the 4-bit counter, then reset
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;
    check("sat_cleared", stall_cnt4, 0);
    drive(1'b0, 1'b1, W'('hAA), 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("sat_cnt4", stall_cnt4, 15);
    check("sat_cnt16", stall_cnt, 20);
    check("sat_data", out_data, 'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_rst_cnt4", stall_cnt4, 0);
    check("sat_rst_cnt16", stall_cnt, 0);
    check("sat_rst_valid", out_valid, 0);

    // 6: random traffic against a FIFO scoreboard
    xfers = 0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      fl   = ($urandom_range(0, 24) == 0);
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      r    = {$urandom, $urandom, $urandom, $urandom};
      drive(fl, iv, iv ? r[W-1:0] : 'x, ordy);
      #2;
      check("rand_valid", out_valid, (q.size() != 0));
      if (out_valid && out_ready && q.size() != 0) begin
        check("rand_data", out_data, q[0]);
        void'(q.pop_front());
        xfers++;
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(in_data);
      @(posedge clk);
      #1;
    end
    check("rand_progress", (xfers > 20), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
